// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Scans DIGITS digits one at a time, holding each one lit for CLK_DIV cycles.
// Each digit is hex-decoded and has its own decimal point, blanking and
// leading-zero suppression. New display data reaches the shadow image only at
// a frame boundary, so a single frame never mixes two loads.

module seg_scan_driver #(
  parameter int DIGITS     = 8,      // number of digits, 1..16
  parameter int CLK_DIV    = 50000,  // clk cycles each digit is lit, >= 2
  parameter bit ACTIVE_LOW = 1'b1    // 1: seg/an active-low, 0: active-high
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{ACTIVE_LOW}};

  // One complete display image: nibbles, decimal points and blank flags.
  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } image_t;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  image_t            pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  image_t            shd_q, shd_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q;

  image_t            in_img;
  logic              tick;
  logic              boundary;
  logic [DIGITS-1:0] sup;
  logic              all_zero;
  logic [3:0]        nib;
  logic [7:0]        pattern;
  logic [DIGITS-1:0] an_onehot;

  // Hex digit to active-high {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h7E;
      4'h1:    hex7 = 7'h30;
      4'h2:    hex7 = 7'h6D;
      4'h3:    hex7 = 7'h79;
      4'h4:    hex7 = 7'h33;
      4'h5:    hex7 = 7'h5B;
      4'h6:    hex7 = 7'h5F;
      4'h7:    hex7 = 7'h70;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h7B;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h1F;
      4'hC:    hex7 = 7'h4E;
      4'hD:    hex7 = 7'h3D;
      4'hE:    hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  assign in_img   = '{data: data_in, dp: dp_in, blank: blank_in};
  assign tick     = en && (presc_q == PRESC_MAX);
  assign boundary = tick && (idx_q == IDX_MAX);

  // Prescaler and digit index: free-run while enabled, parked at 0 otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Pending capture and frame-synchronous shadow update; a load in the
  // boundary cycle bypasses pending so the last load before the boundary wins.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shd_d    = shd_q;
    if (load) begin
      pend_d   = in_img;
      pend_v_d = 1'b1;
    end
    if (boundary && (pend_v_q || load)) begin
      shd_d    = load ? in_img : pend_q;
      pend_v_d = 1'b0;
    end
  end

  // Suppression flags: digit k>0 is a leading zero when it and every higher nibble are zero.
  always_comb begin
    sup      = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero & (shd_q.data[4*k +: 4] == 4'h0);
      sup[k]   = all_zero;
    end
  end

  // Segment and anode pattern for the digit currently selected by idx.
  always_comb begin
    nib       = shd_q.data[4*int'(idx_q) +: 4];
    pattern   = {hex7(nib), shd_q.dp[idx_q]};
    if (lz_en && sup[idx_q]) begin
      pattern[7:1] = 7'h00;
    end
    if (shd_q.blank[idx_q]) begin
      pattern = 8'h00;
    end
    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;
    if (!en) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else begin
      seg_d = ACTIVE_LOW ? ~pattern   : pattern;
      an_d  = ACTIVE_LOW ? ~an_onehot : an_onehot;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the pending and shadow images are reset explicitly because a reset must blank stale display data, not merely restart the scan.
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      shd_q        <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      shd_q        <= shd_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver with DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1.
// A frame lasts 16 cycles; cyc counts clock edges since the scan last
// restarted from digit 0, so frames begin at cyc = 16*n + 1.

module tb_seg_scan_driver;

  localparam int DIGITS     = 4;
  localparam int CLK_DIV    = 4;
  localparam bit ACTIVE_LOW = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS     (DIGITS),
    .CLK_DIV    (CLK_DIV),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run one full frame starting at its first cycle, comparing every cycle to
  // the expected per-digit segments exp = {d3, d2, d1, d0}. Optional loads are
  // issued so they are captured on the edge ending step la / lb (15 = boundary).
  task automatic scan_frame(input string name, input logic [31:0] exp,
                            input int la, input logic [15:0] da,
                            input int lb, input logic [15:0] db);
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fd;
    int         d;
    for (int i = 0; i < 16; i++) begin
      load = 1'b0;
      if (i == la) begin load = 1'b1; data_in = da; end
      if (i == lb) begin load = 1'b1; data_in = db; end
      step();
      d       = i / 4;
      exp_an  = ~(4'b0001 << d);
      exp_seg = exp[8*d +: 8];
      exp_fd  = (i == 15);
      n_checks++;
      if (an !== exp_an) begin
        n_fail++;
        $display("FAIL %s an step %0d: got %h expected %h", name, i, an, exp_an);
      end
      n_checks++;
      if (seg !== exp_seg) begin
        n_fail++;
        $display("FAIL %s seg step %0d: got %h expected %h", name, i, seg, exp_seg);
      end
      n_checks++;
      if (frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL %s frame_done step %0d: got %b expected %b", name, i, frame_done, exp_fd);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    load     = 1'b0;
    lz_en    = 1'b0;
    data_in  = 16'h0000;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset seg cycle %0d: got %h expected ff", i, seg);
      end
      n_checks++;
      if (an !== 4'hF) begin
        n_fail++;
        $display("FAIL reset an cycle %0d: got %h expected f", i, an);
      end
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset frame_done cycle %0d: got %b expected 0", i, frame_done);
      end
    end
    rst_n = 1'b1;
    cyc   = 0;
    // First frame after reset: empty shadow shows 0 on every digit, scan order E,D,B,7.
    scan_frame("reset_first_frame", {8'h03, 8'h03, 8'h03, 8'h03}, 5, 16'h3210, -1, 16'h0);
  endtask

  task automatic test_decode_sweep();
    scan_frame("dec_3210", {8'h0D, 8'h25, 8'h9F, 8'h03}, 5, 16'h7654, -1, 16'h0);
    scan_frame("dec_7654", {8'h1F, 8'h41, 8'h49, 8'h99}, 5, 16'hBA98, -1, 16'h0);
    scan_frame("dec_BA98", {8'hC1, 8'h11, 8'h09, 8'h01}, 5, 16'hFEDC, -1, 16'h0);
    scan_frame("dec_FEDC", {8'h71, 8'h61, 8'h85, 8'h63}, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_load_at_boundary();
    scan_frame("bnd_before", {8'h71, 8'h61, 8'h85, 8'h63}, 15, 16'h0008, -1, 16'h0);
    scan_frame("bnd_after",  {8'h03, 8'h03, 8'h03, 8'h01}, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_tear_free();
    // ABCD loaded while digit 1 is lit, overwritten by 1234 before the boundary.
    scan_frame("tear_old", {8'h03, 8'h03, 8'h03, 8'h01}, 4, 16'hABCD, 9, 16'h1234);
    scan_frame("tear_new", {8'h9F, 8'h25, 8'h0D, 8'h99}, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_leading_zero();
    lz_en = 1'b1;
    dp_in = 4'b1000;
    scan_frame("lz_1234", {8'h9F, 8'h25, 8'h0D, 8'h99}, 5, 16'h0050, -1, 16'h0);
    dp_in = 4'b0000;
    scan_frame("lz_0050", {8'hFE, 8'hFF, 8'h49, 8'h03}, 5, 16'h0000, -1, 16'h0);
  endtask

  task automatic test_blank_enable();
    blank_in = 4'b0001;
    scan_frame("zero_lz", {8'hFF, 8'hFF, 8'hFF, 8'h03}, 5, 16'h0000, -1, 16'h0);
    blank_in = 4'b0000;
    scan_frame("blank0",  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 5, 16'h0000, -1, 16'h0);
    step();
    step();
    n_checks++;
    if (seg !== 8'h03) begin
      n_fail++;
      $display("FAIL unblank seg: got %h expected 03", seg);
    end
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL en_off seg cycle %0d: got %h expected ff", i, seg);
      end
      n_checks++;
      if (an !== 4'hF) begin
        n_fail++;
        $display("FAIL en_off an cycle %0d: got %h expected f", i, an);
      end
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL en_off frame_done cycle %0d: got %b expected 0", i, frame_done);
      end
    end
    en  = 1'b1;
    cyc = 0;
    scan_frame("en_restart", {8'hFF, 8'hFF, 8'hFF, 8'h03}, 5, 16'h5555, -1, 16'h0);
  endtask

  task automatic test_reset_mid_frame();
    step();
    step();
    step();
    load    = 1'b1;
    data_in = 16'h7777;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (seg !== 8'h49) begin
      n_fail++;
      $display("FAIL pre_reset seg: got %h expected 49", seg);
    end
    n_checks++;
    if (an !== 4'hD) begin
      n_fail++;
      $display("FAIL pre_reset an: got %h expected d", an);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_reset seg: got %h expected ff", seg);
    end
    n_checks++;
    if (an !== 4'hF) begin
      n_fail++;
      $display("FAIL mid_reset an: got %h expected f", an);
    end
    rst_n = 1'b1;
    cyc   = 0;
    // Shadow and pending are cleared: zeros (suppressed above digit 0) for two frames.
    scan_frame("post_reset",  {8'hFF, 8'hFF, 8'hFF, 8'h03}, -1, 16'h0, -1, 16'h0);
    scan_frame("post_reset2", {8'hFF, 8'hFF, 8'hFF, 8'h03}, -1, 16'h0, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_load_at_boundary();
    test_tear_free();
    test_leading_zero();
    test_blank_enable();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
